usb_rx_deserializer: RTL and testbench

//  Receive path stage fed by the DPLL: takes recovered line bits (aligned_bit qualified by pulse) plus SE0 state.

---
 rtl/usb_rx_pkg.sv | 24 ++
 rtl/usb_rx_deserializer_nrzi_unstuff.sv | 95 +++++++++
 rtl/usb_rx_deserializer.sv | 220 ++++++++++++++++++++++
 tb/tb_usb_rx_deserializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_pkg
//  Description : Shared types and constants for the USB receive deserializer:
//                FSM state encoding, decoded SYNC pattern, bit-stuff run.
//  Revision    : 1.0  initial release
// ============================================================================
package usb_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_EOP1  = 2'd2,
    ST_ABORT = 2'd3
  } rx_state_e;

  // SYNC after NRZI decode, LSB first: seven 0s then a 1.
  localparam logic [7:0] USB_SYNC_PATTERN = 8'h80;

  // Decoded 1s after which the transmitter inserts a 0.
  localparam int USB_MAX_ONES = 6;

endpackage
`default_nettype wire

// File: rtl/usb_rx_deserializer_nrzi_unstuff.sv
`default_nettype none
// ============================================================================
//  Module      : nrzi_unstuff
//  Description : NRZI decoder plus bit-stuff tracker. Decodes every non-SE0
//                pulse; while stuffing is enabled, drops the bit that follows
//                MAX_ONES consecutive 1s, or flags it if it is a 1.
//  Ports       : clk, rst         clock, synchronous active-high reset
//                pulse_i          bit strobe from the DPLL
//                aligned_bit_i    recovered D+ level (valid with pulse_i)
//                se0_i            SE0 line state (valid with pulse_i)
//                stuff_en_i       stuffing rules apply (packet body)
//                sync_hit_i       SYNC-ending 1 accepted on this pulse
//                line_reset_i     receiver returns to idle on this pulse
//                dec_valid_o      a non-SE0 bit was decoded this cycle
//                dec_bit_o        decoded bit
//                bit_valid_o      decoded bit is a payload bit
//                bit_o            payload bit value
//                stuff_err_o      a 1 arrived where a stuffed 0 was due
//  Revision    : 1.0  initial release
// ============================================================================
module nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int MAX_ONES = USB_MAX_ONES
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_i,
  input  logic aligned_bit_i,
  input  logic se0_i,
  input  logic stuff_en_i,
  input  logic sync_hit_i,
  input  logic line_reset_i,
  output logic dec_valid_o,
  output logic dec_bit_o,
  output logic bit_valid_o,
  output logic bit_o,
  output logic stuff_err_o
);

  localparam int            ONES_W   = $clog2(MAX_ONES + 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(MAX_ONES);

  logic              prev_line_q, prev_line_d;
  logic [ONES_W-1:0] ones_cnt_q,  ones_cnt_d;
  logic              dbit;
  logic              at_stuff;

  // No transition on the line decodes as 1.
  assign dbit        = (aligned_bit_i == prev_line_q);
  assign at_stuff    = (ones_cnt_q == ONES_MAX);
  assign dec_valid_o = pulse_i & ~se0_i;
  assign dec_bit_o   = dbit;
  assign bit_o       = dbit;
  assign bit_valid_o = dec_valid_o & stuff_en_i & ~at_stuff;
  assign stuff_err_o = dec_valid_o & stuff_en_i & at_stuff & dbit;

  always_comb begin
    prev_line_d = prev_line_q;
    ones_cnt_d  = ones_cnt_q;
    if (dec_valid_o) begin
      prev_line_d = aligned_bit_i;
    end
    if (dec_valid_o && stuff_en_i) begin
      // Below ONES_MAX the increment cannot overflow; at ONES_MAX the bit
      // is either the discarded stuff 0 or an error, both restart the run.
      if (at_stuff || !dbit) begin
        ones_cnt_d = '0;
      end else begin
        ones_cnt_d = ones_cnt_q + 1'b1;
      end
    end
    // The SYNC-final 1 is the first 1 of the stuffing run.
    if (sync_hit_i) begin
      ones_cnt_d = ONES_W'(1);
    end
    // Idle line is J; decoding restarts from that reference.
    if (line_reset_i) begin
      prev_line_d = 1'b1;
      ones_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_line_q <= 1'b1;
      ones_cnt_q  <= '0;
    end else begin
      prev_line_q <= prev_line_d;
      ones_cnt_q  <= ones_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_deserializer
//  Description : USB receive deserializer behind the DPLL. SYNC detect,
//                LSB-first byte assembly, EOP detect and error flagging on
//                top of the NRZI/unstuff stage.
//  Ports       : clk, rst         48 MHz clock, synchronous active-high reset
//                aligned_bit_i    recovered D+ level (valid with pulse_i)
//                pulse_i          one-cycle bit strobe
//                se0_i            SE0 line state (valid with pulse_i)
//                rx_data_o [7:0]  last assembled byte, held
//                rx_valid_o       one-cycle strobe, rx_data_o is new
//                rx_active_o      packet in progress
//                rx_error_o       one-cycle strobe: stuff/EOP/alignment error
//  Revision    : 1.0  initial release
// ============================================================================
module usb_rx_deserializer
  import usb_rx_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int MAX_ONES       = USB_MAX_ONES,
  parameter int IDLE_PULSES    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       aligned_bit_i,
  input  logic       pulse_i,
  input  logic       se0_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_active_o,
  output logic       rx_error_o
);

  localparam int               ZERO_W    = $clog2(SYNC_MIN_ZEROS + 1);
  localparam int               J_W       = $clog2(IDLE_PULSES + 1);
  localparam logic [ZERO_W-1:0] ZERO_MIN = ZERO_W'(SYNC_MIN_ZEROS);
  localparam logic [J_W-1:0]   J_LAST    = J_W'(IDLE_PULSES - 1);

  rx_state_e         state_q,     state_d;
  logic [ZERO_W-1:0] zero_cnt_q,  zero_cnt_d;
  logic [2:0]        bit_cnt_q,   bit_cnt_d;
  logic [7:0]        shift_q,     shift_d;
  logic [7:0]        rx_data_q,   rx_data_d;
  logic              rx_valid_q,  rx_valid_d;
  logic              rx_active_q, rx_active_d;
  logic              rx_error_q,  rx_error_d;
  logic              se0_seen_q,  se0_seen_d;
  logic [J_W-1:0]    j_cnt_q,     j_cnt_d;

  logic stuff_en;
  logic sync_hit;
  logic line_reset;
  logic dec_valid;
  logic dec_bit;
  logic bit_valid;
  logic bit_val;
  logic stuff_err;

  assign stuff_en = (state_q == ST_DATA);

  nrzi_unstuff #(
    .MAX_ONES (MAX_ONES)
  ) u_nrzi_unstuff (
    .clk           (clk),
    .rst           (rst),
    .pulse_i       (pulse_i),
    .aligned_bit_i (aligned_bit_i),
    .se0_i         (se0_i),
    .stuff_en_i    (stuff_en),
    .sync_hit_i    (sync_hit),
    .line_reset_i  (line_reset),
    .dec_valid_o   (dec_valid),
    .dec_bit_o     (dec_bit),
    .bit_valid_o   (bit_valid),
    .bit_o         (bit_val),
    .stuff_err_o   (stuff_err)
  );

  always_comb begin
    state_d    = state_q;
    zero_cnt_d = zero_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_error_d = 1'b0;
    se0_seen_d = se0_seen_q;
    j_cnt_d    = j_cnt_q;
    sync_hit   = 1'b0;
    line_reset = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pulse_i && se0_i) begin
          zero_cnt_d = '0;
        end else if (dec_valid) begin
          if (!dec_bit) begin
            if (zero_cnt_q < ZERO_MIN) begin
              zero_cnt_d = zero_cnt_q + 1'b1;
            end
          end else if (zero_cnt_q >= ZERO_MIN) begin
            state_d    = ST_DATA;
            sync_hit   = 1'b1;
            zero_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
          end else begin
            zero_cnt_d = '0;
          end
        end
      end

      ST_DATA: begin
        if (pulse_i && se0_i) begin
          state_d = ST_EOP1;
        end else if (stuff_err) begin
          // The bit is never consumed, so a byte it would complete is lost.
          rx_error_d = 1'b1;
          se0_seen_d = 1'b0;
          j_cnt_d    = '0;
          state_d    = ST_ABORT;
        end else if (bit_valid) begin
          shift_d   = {bit_val, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
          end
        end
      end

      ST_EOP1: begin
        if (pulse_i) begin
          if (se0_i) begin
            rx_error_d = (bit_cnt_q != 3'd0);
            state_d    = ST_IDLE;
          end else begin
            rx_error_d = 1'b1;
            se0_seen_d = 1'b0;
            j_cnt_d    = '0;
            state_d    = ST_ABORT;
          end
        end
      end

      ST_ABORT: begin
        if (pulse_i) begin
          if (se0_i) begin
            j_cnt_d = '0;
            if (se0_seen_q) begin
              state_d = ST_IDLE;
            end else begin
              se0_seen_d = 1'b1;
            end
          end else if (aligned_bit_i) begin
            se0_seen_d = 1'b0;
            if (j_cnt_q == J_LAST) begin
              state_d = ST_IDLE;
            end else begin
              j_cnt_d = j_cnt_q + 1'b1;
            end
          end else begin
            se0_seen_d = 1'b0;
            j_cnt_d    = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every re-entry to IDLE starts from a clean slate.
    if (state_d == ST_IDLE && state_q != ST_IDLE) begin
      line_reset = 1'b1;
      zero_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = '0;
      se0_seen_d = 1'b0;
      j_cnt_d    = '0;
    end

    rx_active_d = (state_d == ST_DATA) || (state_d == ST_EOP1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      zero_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_error_q  <= 1'b0;
      se0_seen_q  <= 1'b0;
      j_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      zero_cnt_q  <= zero_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_active_q <= rx_active_d;
      rx_error_q  <= rx_error_d;
      se0_seen_q  <= se0_seen_d;
      j_cnt_q     <= j_cnt_d;
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_active_o = rx_active_q;
  assign rx_error_o  = rx_error_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_rx_deserializer
//  Description : Directed self-checking bench for usb_rx_deserializer. An
//                NRZI/stuffing encoder drives the line; expected bytes and
//                strobe counts are hand-computed constants.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_usb_rx_deserializer;
  import usb_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       aligned_bit = 1'b1;
  logic       pulse = 1'b0;
  logic       se0 = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_both   = 0;
  logic [7:0] last_data = 8'h00;

  logic line_tb   = 1'b1;
  int   ones_tb   = 0;
  int   gap       = 0;
  int   wire_bits = 0;
  int   base_v    = 0;
  int   base_e    = 0;

  always #5 clk = ~clk;

  usb_rx_deserializer dut (
    .clk           (clk),
    .rst           (rst),
    .aligned_bit_i (aligned_bit),
    .pulse_i       (pulse),
    .se0_i         (se0),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_active_o   (rx_active),
    .rx_error_o    (rx_error)
  );

  // Strobe monitor, sampled 1 ns after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rx_valid) begin
        n_valid   = n_valid + 1;
        last_data = rx_data;
      end
      if (rx_error) n_err = n_err + 1;
      if (rx_valid && rx_error) n_both = n_both + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; one pulse cycle, then `gap` idle cycles.
  task automatic drive(input logic lvl, input logic s);
    aligned_bit = lvl;
    se0         = s;
    pulse       = 1'b1;
    wire_bits   = wire_bits + 1;
    @(negedge clk);
    pulse = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_line(input logic lvl);
    line_tb = lvl;
    drive(lvl, 1'b0);
  endtask

  task automatic send_dbit_raw(input logic b);
    if (!b) line_tb = ~line_tb;
    drive(line_tb, 1'b0);
  endtask

  task automatic send_dbit(input logic b);
    send_dbit_raw(b);
    ones_tb = b ? ones_tb + 1 : 0;
    if (ones_tb == USB_MAX_ONES) begin
      send_dbit_raw(1'b0);
      ones_tb = 0;
    end
  endtask

  task automatic send_sync(input logic chk);
    logic [7:0] p;
    p = USB_SYNC_PATTERN;
    for (int i = 0; i < 7; i++) send_dbit_raw(p[i]);
    if (chk) check("sync_active_before_last", 32'(rx_active), 0);
    send_dbit_raw(p[7]);
    ones_tb = 1;
  endtask

  task automatic send_byte(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_dbit(v[i]);
  endtask

  task automatic send_se0();
    drive(1'b0, 1'b1);
  endtask

  task automatic send_eop();
    send_se0();
    send_se0();
    send_line(1'b1);
  endtask

  task automatic mark();
    base_v = n_valid;
    base_e = n_err;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_data",   32'(rx_data), 0);
    check("reset_valid",  32'(rx_valid), 0);
    check("reset_active", 32'(rx_active), 0);
    check("reset_error",  32'(rx_error), 0);
    rst = 1'b0;

    // 1: SYNC + 0xA5 + SE0,SE0,J
    send_line(1'b1);
    send_line(1'b1);
    mark();
    send_sync(1'b1);
    check("t1_active_after_sync", 32'(rx_active), 1);
    send_byte(8'hA5, 8);
    check("t1_valid_count", 32'(n_valid - base_v), 1);
    check("t1_data", 32'(last_data), 32'h A5);
    send_se0();
    check("t1_active_after_se0_1", 32'(rx_active), 1);
    send_se0();
    check("t1_active_after_se0_2", 32'(rx_active), 0);
    send_line(1'b1);
    check("t1_error_count", 32'(n_err - base_e), 0);

    // 2: 0xFF needs one stuffed 0 -> 9 wire bits
    mark();
    send_sync(1'b0);
    wire_bits = 0;
    send_byte(8'hFF, 8);
    check("t2_wire_bits", 32'(wire_bits), 9);
    check("t2_valid_count", 32'(n_valid - base_v), 1);
    check("t2_data", 32'(last_data), 32'h FF);
    send_eop();
    check("t2_error_count", 32'(n_err - base_e), 0);
    check("t2_active_end", 32'(rx_active), 0);

    // 3: stuff violation, then ABORT exit conditions
    mark();
    send_sync(1'b0);
    for (int i = 0; i < 5; i++) send_dbit_raw(1'b1);
    check("t3_no_error_yet", 32'(rx_error), 0);
    send_dbit_raw(1'b1);
    check("t3_error_strobe", 32'(rx_error), 1);
    check("t3_active_drop", 32'(rx_active), 0);
    send_dbit_raw(1'b1);
    check("t3_valid_count", 32'(n_valid - base_v), 0);
    check("t3_error_count", 32'(n_err - base_e), 1);
    for (int i = 0; i < 7; i++) send_line(1'b1);
    send_sync(1'b0);
    check("t3_still_abort_7j", 32'(rx_active), 0);
    for (int i = 0; i < 8; i++) send_line(1'b1);
    send_sync(1'b0);
    check("t3_idle_after_8j", 32'(rx_active), 1);
    // single-bit SE0 -> error, then two SE0 leave ABORT
    send_se0();
    send_line(1'b1);
    check("t3_single_se0_error", 32'(rx_error), 1);
    check("t3_single_se0_active", 32'(rx_active), 0);
    send_se0();
    send_se0();
    send_line(1'b1);
    send_sync(1'b0);
    check("t3_idle_after_2se0", 32'(rx_active), 1);
    send_eop();
    check("t3_active_end", 32'(rx_active), 0);

    // 4: 0x3C + 3 extra bits then EOP -> alignment error at EOP
    mark();
    send_sync(1'b0);
    send_byte(8'h3C, 8);
    send_byte(8'h05, 3);
    send_se0();
    check("t4_no_error_first_se0", 32'(rx_error), 0);
    send_se0();
    check("t4_error_at_eop", 32'(rx_error), 1);
    check("t4_active_at_eop", 32'(rx_active), 0);
    send_line(1'b1);
    check("t4_valid_count", 32'(n_valid - base_v), 1);
    check("t4_data", 32'(last_data), 32'h 3C);
    check("t4_error_count", 32'(n_err - base_e), 1);

    // 5: 3 idle clocks between pulses; truncated SYNC is ignored
    gap = 3;
    mark();
    send_line(1'b1);
    for (int i = 0; i < 4; i++) send_dbit_raw(1'b0);
    send_dbit_raw(1'b1);
    check("t5_truncated_sync", 32'(rx_active), 0);
    send_line(1'b1);
    send_line(1'b1);
    send_sync(1'b0);
    check("t5_active_after_sync", 32'(rx_active), 1);
    send_byte(8'hA5, 8);
    send_eop();
    check("t5_valid_count", 32'(n_valid - base_v), 1);
    check("t5_data_held", 32'(rx_data), 32'h A5);
    check("t5_error_count", 32'(n_err - base_e), 0);
    check("t5_active_end", 32'(rx_active), 0);
    gap = 0;

    // 6: reset mid-byte, then a clean packet
    send_line(1'b1);
    send_sync(1'b0);
    send_byte(8'h2D, 4);
    rst = 1'b1;
    mark();
    for (int i = 0; i < 6; i++) send_dbit(1'b1);
    check("t6_active_in_reset", 32'(rx_active), 0);
    rst     = 1'b0;
    line_tb = 1'b1;
    ones_tb = 0;
    check("t6_no_valid_in_reset", 32'(n_valid - base_v), 0);
    check("t6_no_error_in_reset", 32'(n_err - base_e), 0);
    send_line(1'b1);
    send_line(1'b1);
    send_sync(1'b0);
    send_byte(8'h2D, 8);
    send_eop();
    check("t6_valid_count", 32'(n_valid - base_v), 1);
    check("t6_data", 32'(last_data), 32'h 2D);
    check("t6_error_count", 32'(n_err - base_e), 0);

    check("valid_error_overlap", 32'(n_both), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
